// File: rtl/decode_stage.sv
// Registered RV32I decode stage: one-entry output register with valid/ready handshake, flush and illegal counter.
// Optional RV_M_EXT_EN: makes OP funct7=0000001 (M extension) legal and drives out_mext.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [9:0]       out_class,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic             out_alt,
  output logic             out_mext,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [4:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [9:0]      d_class;
  logic            d_ill;
  logic [31:0]     imm32;
  logic [XLEN-1:0] d_imm;
  logic            accept;

  assign opc      = in_instr[6:2];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef RV_M_EXT_EN
  logic d_mext;
`endif

  always_comb begin
    d_class = '0;
    d_ill   = 1'b0;
    imm32   = '0;
`ifdef RV_M_EXT_EN
    d_mext  = 1'b0;
`endif
    case (opc)
      OPC_OP: begin
        d_class[0] = 1'b1;
        if (f7 == 7'b0000000)
          d_ill = 1'b0;
        else if (f7 == 7'b0100000)
          d_ill = !((f3 == 3'b000) || (f3 == 3'b101));
`ifdef RV_M_EXT_EN
        else if (f7 == 7'b0000001)
          d_mext = 1'b1;
`endif
        else
          d_ill = 1'b1;
      end
      OPC_OPIMM: begin
        d_class[1] = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        if (f3 == 3'b001)
          d_ill = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          d_ill = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
      end
      OPC_LOAD: begin
        d_class[2] = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        d_ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        d_class[3] = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        d_ill = (f3 >= 3'b011);
      end
      OPC_BRANCH: begin
        d_class[4] = 1'b1;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        d_ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LUI: begin
        d_class[5] = 1'b1;
        imm32 = {in_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        d_class[6] = 1'b1;
        imm32 = {in_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        d_class[7] = 1'b1;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        d_class[8] = 1'b1;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        d_ill = (f3 != 3'b000);
      end
      OPC_SYSTEM, OPC_FENCE: d_class[9] = 1'b1;
      default: d_ill = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11)
      d_ill = 1'b1;
    // An illegal entry carries no class or immediate so execute cannot act on it.
    if (d_ill) begin
      d_class = '0;
      imm32   = '0;
`ifdef RV_M_EXT_EN
      d_mext  = 1'b0;
`endif
    end
    d_imm = '0;
    d_imm[31:0] = imm32;
    for (int i = 32; i < XLEN; i++)
      d_imm[i] = imm32[31];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_class   <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_funct3  <= '0;
      out_alt     <= 1'b0;
      out_imm     <= '0;
      out_illegal <= 1'b0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_class   <= d_class;
      out_rd      <= in_instr[11:7];
      out_rs1     <= in_instr[19:15];
      out_rs2     <= in_instr[24:20];
      out_funct3  <= f3;
      out_alt     <= in_instr[30];
      out_imm     <= d_imm;
      out_illegal <= d_ill;
      if (d_ill && (illegal_cnt != CNT_MAX))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RV_M_EXT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_mext <= 1'b0;
    else if (!flush && accept)
      out_mext <= d_mext;
  end
`else
  assign out_mext = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Table-driven scoreboard bench for decode_stage: decode vectors, backpressure, stall, flush, reset, counter saturation.
module tb_decode_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  cls;
    logic [31:0] imm;
    logic        ill;
    logic        mext;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } sb_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_instr = '0;
  logic [XLEN-1:0]  in_pc = '0;
  logic             in_ready, out_valid, out_alt, out_mext, out_illegal;
  logic [XLEN-1:0]  out_pc, out_imm;
  logic [9:0]       out_class;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic [2:0]       out_funct3;
  logic [CNT_W-1:0] illegal_cnt;

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_class(out_class),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_alt(out_alt), .out_mext(out_mext), .out_imm(out_imm), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  vec_t cur;
  vec_t tbl[$];
  sb_t  q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] instr, input logic [9:0] cls, input logic [31:0] imm,
                     input logic ill, input logic mext);
    vec_t v;
    v.instr = instr; v.cls = cls; v.imm = imm; v.ill = ill; v.mext = mext;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop and compare on leave, discard on flush, clear on reset.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      q.delete();
      exp_cnt = 0;
    end else if (flush) begin
      if (out_valid && q.size() > 0) q.delete(0);
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("pc",      out_pc,      e.pc);
          chk("class",   out_class,   e.v.cls);
          chk("rd",      out_rd,      e.v.instr[11:7]);
          chk("rs1",     out_rs1,     e.v.instr[19:15]);
          chk("rs2",     out_rs2,     e.v.instr[24:20]);
          chk("funct3",  out_funct3,  e.v.instr[14:12]);
          chk("alt",     out_alt,     e.v.instr[30]);
          chk("mext",    out_mext,    e.v.mext);
          chk("imm",     out_imm,     e.v.imm);
          chk("illegal", out_illegal, e.v.ill);
        end
      end
      if (in_valid && in_ready) begin
        e.v = cur; e.pc = in_pc;
        q.push_back(e);
        if (cur.ill && exp_cnt < 255) exp_cnt++;
      end
    end
  end

  initial begin
    vec_t ill_v;
    logic acc;
    int   guard;

    add(32'h00500093, 10'h002, 32'h00000005, 1'b0, 1'b0); // addi x1,x0,5
    add(32'h0020A423, 10'h008, 32'h00000008, 1'b0, 1'b0); // sw x2,8(x1)
    add(32'hFE000EE3, 10'h010, 32'hFFFFFFFC, 1'b0, 1'b0); // beq x0,x0,-4
`ifdef RV_M_EXT_EN
    add(32'h022081B3, 10'h001, 32'h00000000, 1'b0, 1'b1); // mul
`else
    add(32'h022081B3, 10'h000, 32'h00000000, 1'b1, 1'b0); // mul
`endif
    add(32'h123452B7, 10'h020, 32'h12345000, 1'b0, 1'b0); // lui
    add(32'hFFFFF097, 10'h040, 32'hFFFFF000, 1'b0, 1'b0); // auipc
    add(32'h008000EF, 10'h080, 32'h00000008, 1'b0, 1'b0); // jal x1,8
    add(32'hFFF100E7, 10'h100, 32'hFFFFFFFF, 1'b0, 1'b0); // jalr x1,-1(x2)
    add(32'hFF022183, 10'h004, 32'hFFFFFFF0, 1'b0, 1'b0); // lw x3,-16(x4)
    add(32'h00000073, 10'h200, 32'h00000000, 1'b0, 1'b0); // ecall
    add(32'h0FF0000F, 10'h200, 32'h00000000, 1'b0, 1'b0); // fence
    add(32'h402081B3, 10'h001, 32'h00000000, 1'b0, 1'b0); // sub
    add(32'h40105093, 10'h002, 32'h00000401, 1'b0, 1'b0); // srai
    add(32'h00005003, 10'h004, 32'h00000000, 1'b0, 1'b0); // lhu
    add(32'h00001023, 10'h008, 32'h00000000, 1'b0, 1'b0); // sh
    add(32'h00000001, 10'h000, 32'h00000000, 1'b1, 1'b0); // compressed space
    add(32'h0000007F, 10'h000, 32'h00000000, 1'b1, 1'b0); // unknown opcode
    add(32'h02001013, 10'h000, 32'h00000000, 1'b1, 1'b0); // slli with funct7!=0
    add(32'h40001033, 10'h000, 32'h00000000, 1'b1, 1'b0); // OP alt with funct3=001
    add(32'h00003003, 10'h000, 32'h00000000, 1'b1, 1'b0); // LOAD funct3=011
    add(32'h00003023, 10'h000, 32'h00000000, 1'b1, 1'b0); // STORE funct3=011
    add(32'h00002063, 10'h000, 32'h00000000, 1'b1, 1'b0); // BRANCH funct3=010
    add(32'h00001067, 10'h000, 32'h00000000, 1'b1, 1'b0); // JALR funct3=001
    ill_v.instr = 32'h0; ill_v.cls = '0; ill_v.imm = '0; ill_v.ill = 1'b1; ill_v.mext = 1'b0;
    cur = ill_v;

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cnt",       illegal_cnt, 0);
    chk("rst_class",     out_class, 0);
    chk("rst_imm",       out_imm, 0);
    chk("rst_pc",        out_pc, 0);
    chk("rst_illegal",   out_illegal, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Full-throughput pass
    out_ready = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      cur = tbl[i]; in_instr = tbl[i].instr; in_pc = 32'h1000 + 32'(4 * i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("drain_full", q.size(), 0);
    chk("cnt_table", illegal_cnt, exp_cnt);

    // Random backpressure pass
    for (int i = 0; i < tbl.size(); i++) begin
      cur = tbl[i]; in_instr = tbl[i].instr; in_pc = 32'h2000 + 32'(4 * i); in_valid = 1'b1;
      guard = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = in_ready;
        step();
        guard++;
      end while (!acc && guard < 50);
      if (!acc) chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin step(); guard++; end
    chk("drain_bp", q.size(), 0);

    // Stall with pending input, then leave+accept on the same edge
    out_ready = 1'b0;
    cur = tbl[0]; in_instr = tbl[0].instr; in_pc = 32'h3000; in_valid = 1'b1;
    step();
    cur = tbl[1]; in_instr = tbl[1].instr; in_pc = 32'h3004;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_pc", out_pc, 32'h3000);
      chk("stall_imm", out_imm, 32'h5);
      chk("stall_class", out_class, 10'h002);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("swap_valid", out_valid, 1);
    chk("swap_pc", out_pc, 32'h3004);
    step(); step();
    chk("drain_stall", q.size(), 0);

    // Flush with a held entry and an illegal instruction pending
    out_ready = 1'b0;
    cur = tbl[0]; in_instr = tbl[0].instr; in_pc = 32'h4000; in_valid = 1'b1;
    step();
    cur = ill_v; in_instr = 32'h00000001; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_cnt", illegal_cnt, exp_cnt);
    chk("flush_q", q.size(), 0);

    // Asynchronous reset while stalled
    cur = tbl[2]; in_instr = tbl[2].instr; in_pc = 32'h5000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_cnt", illegal_cnt, 0);
    chk("async_rst_pc", out_pc, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", out_valid, 0);

    // Counter saturation: 256 illegal accepts, then one more
    out_ready = 1'b1;
    cur = ill_v; in_instr = 32'h0; in_pc = 32'h6000; in_valid = 1'b1;
    repeat (254) step();
    in_valid = 1'b0;
    step();
    chk("cnt_254", illegal_cnt, 254);
    in_valid = 1'b1;
    repeat (2) step();
    in_valid = 1'b0;
    step(); step();
    chk("cnt_sat_256", illegal_cnt, 255);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("cnt_sat_257", illegal_cnt, 255);
    chk("drain_sat", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
